clk_div_ctrl: RTL and testbench
===============================

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter: DEFAULT_HALF, default 5, half-period code loaded at reset (half-period = code+1 input cycles).
REQ-002 clk_12mhz  input  1  sole clock, all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 en  input  1  run request; high = generate divided clock, low = stop at period boundary.
REQ-005 cfg_valid  input  1  new half-period code offered.
REQ-006 cfg_half  input  8  half-period code; high and low phases each last cfg_half+1 cycles.
REQ-007 cfg_ready  output  1  controller can accept a code this cycle.
REQ-008 clk_out  output  1  registered divided clock, 50% duty.
REQ-009 tick  output  1  registered one-cycle pulse, high in the cycle clk_out goes 0->1.
REQ-010 running  output  1  high in RUN and PEND states.
REQ-011 cur_half  output  8  half-period code currently in use.

Function
REQ-012 States SHALL be IDLE, RUN, PEND; 8-bit half counter cnt; 8-bit pending register pend_half.
REQ-013 cfg_ready SHALL be 1 in IDLE and RUN, 0 in PEND; a transfer occurs on cfg_valid & cfg_ready.
REQ-014 IDLE: clk_out=0, cnt=0, tick=0; a transfer SHALL load cur_half directly, next cycle.
REQ-015 IDLE with en=1 SHALL go to RUN next cycle with clk_out=1, tick=1, cnt=0; a code transferred in that same cycle SHALL govern the first high phase.
REQ-016 RUN/PEND: when cnt != cur_half, cnt SHALL increment; when cnt == cur_half, cnt SHALL clear and clk_out SHALL toggle.
REQ-017 RUN transfer SHALL store pend_half and enter PEND; cur_half SHALL NOT change mid-period.
REQ-018 PEND: at the 0->1 toggle (clk_out=0, cnt==cur_half), cur_half SHALL take pend_half and state SHALL return to RUN, so the new high phase uses the new code.
REQ-019 Stop: with en=0 sampled at the end of a low phase (clk_out=0, cnt==cur_half), the block SHALL enter IDLE instead of toggling; clk_out stays 0 and tick stays 0.
REQ-020 Stop from PEND SHALL load pend_half into cur_half on entering IDLE.
REQ-021 en deasserted during a high phase SHALL NOT truncate it; the high and following low phases complete in full.
REQ-022 en re-asserted before the stop boundary SHALL cancel the stop with no gap in clk_out.
REQ-023 Code 0 SHALL give divide-by-2 (toggle every cycle); code 255 SHALL give half-period 256 with no counter overflow.
REQ-024 tick SHALL be 1 exactly in cycles where clk_out changes 0->1 and never otherwise.

Reset
REQ-025 rst=1 at a rising edge SHALL force, from any state and mid-period: state=IDLE, clk_out=0, tick=0, cnt=0, running=0, cur_half=DEFAULT_HALF, pend_half=DEFAULT_HALF, cfg_ready=1.
REQ-026 rst SHALL take priority over en and cfg_valid in the same cycle.

Verification
REQ-027 Reset, en=1 held, default code -> clk_out high 6 cycles / low 6 cycles repeating; tick every 12 cycles; running=1.
REQ-028 RUN with code 5, transfer cfg_half=2 mid high phase -> cfg_ready=0 until end of the current low phase; next high and low phases each 3 cycles; cur_half=2.
REQ-029 en dropped at cycle 2 of the high phase (code 5) -> remaining high (4 cycles) + 6 low cycles, then IDLE, clk_out=0, running=0, no further tick.
REQ-030 Code 0 with en=1 -> clk_out toggles every cycle, tick every 2 cycles; code 255 -> 256-cycle phases.
REQ-031 rst pulsed mid low phase while in PEND -> next cycle clk_out=0, running=0, cur_half=5, cfg_ready=1.
REQ-032 en=1 and cfg_valid=1 with cfg_half=3 in the same IDLE cycle -> first high phase lasts 4 cycles.

Source files
------------

// File: rtl/clk_div_ctrl_if.sv
// Handshake and status bundle for the programmable clock divider.
interface clk_div_ctrl_if;
  logic       en;
  logic       cfg_valid;
  logic [7:0] cfg_half;
  logic       cfg_ready;
  logic       clk_out;
  logic       tick;
  logic       running;
  logic [7:0] cur_half;

  modport master (
    output en, cfg_valid, cfg_half,
    input  cfg_ready, clk_out, tick, running, cur_half
  );

  modport slave (
    input  en, cfg_valid, cfg_half,
    output cfg_ready, clk_out, tick, running, cur_half
  );
endinterface

// File: rtl/clk_div_ctrl.sv
// Programmable 50%-duty clock divider with glitch-free code change and
// stop-at-period-boundary behaviour.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | stopped, clk_out held low, codes load cur_half directly
//   RUN   | dividing with cur_half, a new code may be accepted
//   PEND  | dividing, new code parked in pend_half until next 0->1 edge
module clk_div_ctrl #(
  parameter logic [7:0] DEFAULT_HALF = 8'd5
) (
  input logic          clk_12mhz,
  input logic          rst,
  clk_div_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       clk_q, clk_d;
  logic       tick_q, tick_d;
  logic [7:0] cur_q, cur_d;
  logic [7:0] pend_q, pend_d;

  logic cfg_ready;
  logic xfer;
  logic wrap;

  assign cfg_ready     = (state_q != PEND);
  assign xfer          = bus.cfg_valid && cfg_ready;
  assign wrap          = (cnt_q == cur_q);

  assign bus.cfg_ready = cfg_ready;
  assign bus.clk_out   = clk_q;
  assign bus.tick      = tick_q;
  assign bus.running   = (state_q != IDLE);
  assign bus.cur_half  = cur_q;

  // State and datapath registers; reset wins over every other input.
  always_ff @(posedge clk_12mhz) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
      cur_q   <= DEFAULT_HALF;
      pend_q  <= DEFAULT_HALF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state, counter, divided-clock and code-update decisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clk_d   = clk_q;
    tick_d  = 1'b0;
    cur_d   = cur_q;
    pend_d  = pend_q;

    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        clk_d = 1'b0;
        if (xfer) cur_d = bus.cfg_half;
        if (bus.en) begin
          state_d = RUN;
          clk_d   = 1'b1;
          tick_d  = 1'b1;
        end
      end

      RUN, PEND: begin
        // Only RUN can see a transfer; the code waits for the next period.
        if (xfer) begin
          pend_d  = bus.cfg_half;
          state_d = PEND;
        end
        if (!wrap) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          cnt_d = 8'd0;
          if (clk_q) begin
            clk_d = 1'b0;
          end else if (!bus.en) begin
            // End of a low phase with no run request: park instead of toggling.
            state_d = IDLE;
            clk_d   = 1'b0;
            if (state_q == PEND) cur_d = pend_q;
            else if (xfer)       cur_d = bus.cfg_half;
          end else begin
            clk_d  = 1'b1;
            tick_d = 1'b1;
            if (state_q == PEND) begin
              cur_d   = pend_q;
              state_d = RUN;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
        clk_d   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed scenarios plus randomized
// traffic, compared every cycle against a phase-level reference model.
module tb_clk_div_ctrl;

  logic clk_12mhz;
  logic rst;

  clk_div_ctrl_if bus ();

  clk_div_ctrl #(.DEFAULT_HALF(8'd5)) dut (
    .clk_12mhz (clk_12mhz),
    .rst       (rst),
    .bus       (bus)
  );

  initial clk_12mhz = 1'b0;
  always #42 clk_12mhz = ~clk_12mhz;

  int total = 0;
  int bad   = 0;

  // Reference model: divider described as phases with a remaining length.
  bit       m_on;
  bit       m_level;
  int       m_left;
  int       m_cur;
  int       m_pend;
  bit       m_has_pend;
  bit       m_tick;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0d expected=%0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_step(input bit e, input bit v, input int h, input bit r);
    bit xfer;
    bit had_pend;
    if (r) begin
      m_on = 0; m_level = 0; m_left = 0; m_cur = 5; m_pend = 5;
      m_has_pend = 0; m_tick = 0;
      return;
    end
    xfer     = v && !m_has_pend;
    had_pend = m_has_pend;
    m_tick   = 0;
    if (!m_on) begin
      if (xfer) m_cur = h;
      if (e) begin
        m_on = 1; m_level = 1; m_left = m_cur + 1; m_tick = 1;
      end
      return;
    end
    if (xfer) begin
      m_pend = h; m_has_pend = 1;
    end
    m_left--;
    if (m_left == 0) begin
      if (m_level) begin
        m_level = 0; m_left = m_cur + 1;
      end else if (!e) begin
        m_on = 0;
        if (had_pend) m_cur = m_pend;
        else if (xfer) m_cur = h;
        m_has_pend = 0;
      end else begin
        if (had_pend) begin
          m_cur = m_pend; m_has_pend = 0;
        end
        m_level = 1; m_left = m_cur + 1; m_tick = 1;
      end
    end
  endtask

  task automatic cyc(input bit e, input bit v, input logic [7:0] h, input bit r);
    bus.en        = e;
    bus.cfg_valid = v;
    bus.cfg_half  = h;
    rst           = r;
    @(posedge clk_12mhz);
    model_step(e, v, int'(h), r);
    #1;
    check("clk_out",   {31'd0, bus.clk_out},   {31'd0, m_on & m_level});
    check("tick",      {31'd0, bus.tick},      {31'd0, m_tick});
    check("running",   {31'd0, bus.running},   {31'd0, m_on});
    check("cur_half",  {24'd0, bus.cur_half},  m_cur);
    check("cfg_ready", {31'd0, bus.cfg_ready}, {31'd0, !m_has_pend});
  endtask

  initial begin
    int n;
    int ticks;
    bus.en = 0; bus.cfg_valid = 0; bus.cfg_half = 0; rst = 1;

    // Reset state.
    cyc(0, 0, 8'd0, 1);
    cyc(0, 0, 8'd0, 1);
    check("rst_clk_out", {31'd0, bus.clk_out}, 0);
    check("rst_running", {31'd0, bus.running}, 0);
    check("rst_cur",     {24'd0, bus.cur_half}, 5);
    check("rst_ready",   {31'd0, bus.cfg_ready}, 1);

    // Default code, en held: 6 high / 6 low, tick every 12 cycles.
    ticks = 0;
    for (int i = 0; i < 48; i++) begin
      cyc(1, 0, 8'd0, 0);
      if (bus.tick) ticks++;
    end
    check("default_ticks", ticks, 4);

    // New code 2 offered two cycles into a high phase.
    cyc(0, 0, 8'd0, 1);
    cyc(1, 0, 8'd0, 0);
    cyc(1, 0, 8'd0, 0);
    cyc(1, 1, 8'd2, 0);
    check("pend_ready", {31'd0, bus.cfg_ready}, 0);
    check("pend_cur",   {24'd0, bus.cur_half}, 5);
    for (int i = 0; i < 30; i++) cyc(1, 0, 8'd0, 0);
    check("new_cur", {24'd0, bus.cur_half}, 2);

    // en dropped at cycle 2 of a high phase: 4 high + 6 low remain.
    cyc(0, 0, 8'd0, 1);
    cyc(1, 0, 8'd0, 0);
    cyc(1, 0, 8'd0, 0);
    n = 0;
    do begin
      cyc(0, 0, 8'd0, 0);
      if (bus.running) n++;
    end while (bus.running && n < 400);
    check("stop_len", n, 10);
    for (int i = 0; i < 20; i++) cyc(0, 0, 8'd0, 0);

    // Code 0 then code 255.
    cyc(0, 1, 8'd0, 0);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 8'd0, 0);
      if (bus.tick) ticks++;
    end
    check("div2_ticks", ticks, 10);
    cyc(0, 0, 8'd0, 1);
    cyc(1, 1, 8'd255, 0);
    n = 0;
    while (bus.clk_out && n < 1000) begin
      n++;
      cyc(1, 0, 8'd0, 0);
    end
    check("half255_high", n, 256);
    for (int i = 0; i < 300; i++) cyc(1, 0, 8'd0, 0);

    // Reset mid low phase while a code is pending.
    cyc(0, 0, 8'd0, 1);
    for (int i = 0; i < 8; i++) cyc(1, 0, 8'd0, 0);
    cyc(1, 1, 8'd9, 0);
    check("pend_before_rst", {31'd0, bus.cfg_ready}, 0);
    cyc(1, 1, 8'd7, 1);
    check("rst_pend_clk",     {31'd0, bus.clk_out}, 0);
    check("rst_pend_running", {31'd0, bus.running}, 0);
    check("rst_pend_cur",     {24'd0, bus.cur_half}, 5);
    check("rst_pend_ready",   {31'd0, bus.cfg_ready}, 1);

    // Code and en in the same idle cycle: first high phase is 4 cycles.
    cyc(1, 1, 8'd3, 0);
    n = 0;
    while (bus.clk_out && n < 100) begin
      n++;
      cyc(1, 0, 8'd0, 0);
    end
    check("first_high_len", n, 4);

    // Randomized traffic.
    for (int i = 0; i < 6000; i++) begin
      bit         e, v, r;
      logic [7:0] h;
      e = ($urandom_range(99) < 90);
      v = ($urandom_range(99) < 6);
      r = ($urandom_range(999) < 3);
      h = ($urandom_range(19) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(12));
      cyc(e, v, h, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
